// File: rtl/banner_pkg.sv
// Shared definitions for the LED banner and its message loader.
// DIGIT_W is the single source for the hex digit width; banner_state_e
// names the loader occupancy states; cnt_w() sizes an occupancy counter
// able to hold 0..n.
package banner_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } banner_state_e;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/banner_msg_loader_if.sv
// Digit-feed / publish bundle between a digit source and banner_msg_loader.
//   din_valid/din/din_ready : one hex digit per accepted cycle
//   commit/clear            : level controls sampled every edge
//   data/data_upd           : published message and its one-cycle update pulse
//   count                   : digits currently held in the shadow register
// master = digit source, slave = loader.
interface banner_msg_loader_if #(parameter int N = 10);
   import banner_pkg::*;

   localparam int CW = cnt_w(N);

   logic                   din_valid;
   logic [DIGIT_W-1:0]     din;
   logic                   din_ready;
   logic                   commit;
   logic                   clear;
   logic [DIGIT_W*N-1:0]   data;
   logic                   data_upd;
   logic [CW-1:0]          count;

   modport master (output din_valid, din, commit, clear,
                   input  din_ready, data, data_upd, count);

   modport slave  (input  din_valid, din, commit, clear,
                   output din_ready, data, data_upd, count);

endinterface

// File: rtl/banner_digit_shreg.sv
// N-deep nibble shift register with occupancy counter.
//   shift      : push din into the low nibble, bump count
//   zero       : synchronous load-zero of shadow and count (wins over shift)
//   shadow/count         : registered contents
//   shadow_nxt/count_nxt : contents after this cycle's shift, before zeroing;
//                          the loader publishes from these so a digit
//                          accepted alongside a commit is included.
module banner_digit_shreg
   import banner_pkg::*;
#(
   parameter int N  = 10,
   localparam int CW = cnt_w(N),
   localparam int W  = DIGIT_W * N
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               shift,
   input  logic               zero,
   input  logic [DIGIT_W-1:0] din,
   output logic [W-1:0]       shadow,
   output logic [W-1:0]       shadow_nxt,
   output logic [CW-1:0]      count,
   output logic [CW-1:0]      count_nxt
);

   // Shift-and-or keeps this legal for N=1 where a part-select would be empty.
   assign shadow_nxt = shift ? ((shadow << DIGIT_W) | W'(din)) : shadow;
   assign count_nxt  = shift ? count + CW'(1) : count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
         count  <= '0;
      end else if (zero) begin
         shadow <= '0;
         count  <= '0;
      end else begin
         shadow <= shadow_nxt;
         count  <= count_nxt;
      end
   end

endmodule

// File: rtl/banner_msg_loader.sv
// Assembles hex digits into a shadow register and publishes the whole
// message as a stable 4*N-bit word with a one-cycle data_upd pulse.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : digit handshake, commit/clear controls, data/data_upd/count
// AUTO_COMMIT=1 publishes on the edge that accepts the N-th digit.
module banner_msg_loader
   import banner_pkg::*;
#(
   parameter int N           = 10,
   parameter int AUTO_COMMIT = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   banner_msg_loader_if.slave   bus
);

   localparam int CW = cnt_w(N);
   localparam int W  = DIGIT_W * N;

   localparam logic [1:0] S_EMPTY   = EMPTY;
   localparam logic [1:0] S_FILLING = FILLING;
   localparam logic [1:0] S_FULL    = FULL;

   logic [1:0]    state, state_nxt;
   logic [W-1:0]  shadow, shadow_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          acc, full_nxt, auto_fire, fire, zero;

   // Ready comes from registered state only; clear does not mask it.
   assign bus.din_ready = (state != S_FULL);

   // Clear drops any digit offered in the same cycle.
   assign acc       = bus.din_valid & bus.din_ready & ~bus.clear;
   assign full_nxt  = (count_nxt == CW'(N));
   assign auto_fire = (AUTO_COMMIT != 0) & acc & full_nxt;
   // Commit judges the post-accept count, so "digit + commit" publishes it.
   assign fire      = ~bus.clear & (count_nxt != '0) & (bus.commit | auto_fire);
   assign zero      = bus.clear | fire;

   banner_digit_shreg #(.N(N)) u_shreg (
      .clk        (clk),
      .reset_n    (reset_n),
      .shift      (acc),
      .zero       (zero),
      .din        (bus.din),
      .shadow     (shadow),
      .shadow_nxt (shadow_nxt),
      .count      (count),
      .count_nxt  (count_nxt)
   );

   always_comb begin
      state_nxt = S_FILLING;
      if (zero || count_nxt == '0) state_nxt = S_EMPTY;
      else if (full_nxt)           state_nxt = S_FULL;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_EMPTY;
         bus.data     <= '0;
         bus.data_upd <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.data_upd <= fire;
         if (fire) bus.data <= shadow_nxt;
      end
   end

   assign bus.count = count;

endmodule

// File: tb/tb_banner_msg_loader.sv
// Self-checking bench for banner_msg_loader (N=10): directed scenarios plus
// randomized traffic against a digit-queue reference model. A second
// instance with AUTO_COMMIT=1 covers automatic publication.
module tb_banner_msg_loader;

   localparam int N = 10;
   localparam int W = 4 * N;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   banner_msg_loader_if #(.N(N)) bus ();
   banner_msg_loader_if #(.N(N)) bus_ac ();

   banner_msg_loader #(.N(N), .AUTO_COMMIT(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave));

   banner_msg_loader #(.N(N), .AUTO_COMMIT(1)) u_dut_ac (
      .clk(clk), .reset_n(reset_n), .bus(bus_ac.slave));

   int vec = 0;
   int err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      if (obs !== exp) begin
         err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the digits held, in arrival order, and the last word.
   int           q[$];
   logic [W-1:0] m_data;
   logic         m_upd;

   function automatic logic [W-1:0] fold();
      logic [W-1:0] w = '0;
      foreach (q[i]) w = (w << 4) | W'(q[i]);
      return w;
   endfunction

   task automatic model_reset();
      q.delete();
      m_data = '0;
      m_upd  = 1'b0;
   endtask

   task automatic check_all(input string pfx);
      chk({pfx, ".data"},  64'(bus.data),      64'(m_data));
      chk({pfx, ".upd"},   64'(bus.data_upd),  64'(m_upd));
      chk({pfx, ".count"}, 64'(bus.count),     64'(q.size()));
      chk({pfx, ".ready"}, 64'(bus.din_ready), 64'(q.size() != N));
   endtask

   // Called just after a falling edge: drive one cycle, step model, check.
   task automatic step(input logic v, input logic [3:0] d, input logic c, input logic cl);
      bus.din_valid = v;
      bus.din       = d;
      bus.commit    = c;
      bus.clear     = cl;
      m_upd = 1'b0;
      if (cl) begin
         q.delete();
      end else begin
         if (v && q.size() < N) q.push_back(int'(d));
         if (c && q.size() > 0) begin
            m_data = fold();
            q.delete();
            m_upd  = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.commit    = 1'b0;
      bus.clear     = 1'b0;
      check_all("step");
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   int pulses[$];
   logic [W-1:0] words[$];
   int ready_low;

   initial begin
      bus.din_valid = 0; bus.din = 0; bus.commit = 0; bus.clear = 0;
      bus_ac.din_valid = 0; bus_ac.din = 0; bus_ac.commit = 0; bus_ac.clear = 0;
      model_reset();
      do_reset();

      // Reset then idle
      chk("rst.data",  64'(bus.data),      64'h0);
      chk("rst.upd",   64'(bus.data_upd),  64'h0);
      chk("rst.count", 64'(bus.count),     64'h0);
      chk("rst.ready", 64'(bus.din_ready), 64'h1);
      step(0, 0, 0, 0);

      // Full load 9..0, an extra digit while full, then commit
      for (int i = 9; i >= 0; i--) step(1, 4'(i), 0, 0);
      chk("full.ready", 64'(bus.din_ready), 64'h0);
      step(1, 4'hE, 0, 0);
      chk("full.count_held", 64'(bus.count), 64'd10);
      step(0, 0, 1, 0);
      chk("full.word", 64'(bus.data), 64'h9876543210);
      chk("full.pulse", 64'(bus.data_upd), 64'h1);
      step(0, 0, 0, 0);
      chk("full.pulse_end", 64'(bus.data_upd), 64'h0);

      // Partial commit, then an empty commit
      step(1, 4'hA, 0, 0); step(1, 4'hB, 0, 0); step(1, 4'hC, 0, 0);
      step(0, 0, 1, 0);
      chk("part.word", 64'(bus.data), 64'h0000000ABC);
      step(0, 0, 1, 0);
      chk("part.nopulse", 64'(bus.data_upd), 64'h0);
      chk("part.held", 64'(bus.data), 64'h0000000ABC);

      // Digit accepted alongside commit
      step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0);
      step(1, 4'hD, 1, 0);
      chk("simul.word", 64'(bus.data), 64'h000000012D);

      // clear + commit + digit together
      step(1, 4'h3, 0, 0); step(1, 4'h4, 0, 0);
      step(1, 4'h5, 1, 1);
      chk("clr.count", 64'(bus.count), 64'h0);
      chk("clr.data", 64'(bus.data), 64'h000000012D);
      chk("clr.nopulse", 64'(bus.data_upd), 64'h0);

      // Back-to-back commits with a digit each cycle
      step(1, 4'h7, 1, 0);
      step(1, 4'h8, 1, 0);
      chk("b2b.word", 64'(bus.data), 64'h8);

      // Asynchronous reset mid-fill at count 5 (data currently non-zero)
      for (int i = 0; i < 5; i++) step(1, 4'(i + 1), 0, 0);
      chk("mid.count5", 64'(bus.count), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_all("post_rst");

      // AUTO_COMMIT: 20 digits 0..3 cycling, valid held
      ready_low = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus_ac.din_ready !== 1'b1) ready_low++;
         bus_ac.din_valid = 1'b1;
         bus_ac.din = 4'(i % 4);
         @(posedge clk);
         @(negedge clk);
         if (bus_ac.data_upd === 1'b1) begin
            pulses.push_back(i);
            words.push_back(bus_ac.data);
         end
      end
      bus_ac.din_valid = 1'b0;
      if (bus_ac.din_ready !== 1'b1) ready_low++;
      chk("ac.ready_low", 64'(ready_low), 64'h0);
      chk("ac.pulses", 64'(pulses.size()), 64'd2);
      if (pulses.size() == 2) begin
         chk("ac.spacing", 64'(pulses[1] - pulses[0]), 64'd10);
         chk("ac.word0", 64'(words[0]), 64'h0123012301);
         chk("ac.word1", 64'(words[1]), 64'h2301230123);
      end
      chk("ac.count", 64'(bus_ac.count), 64'h0);

      // Randomized traffic; bursts of few commits let the register fill up
      for (int i = 0; i < 600; i++) begin
         logic v, c, cl;
         v  = ($urandom_range(0, 9) < 6);
         c  = (i % 100 < 50) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 29) == 0);
         cl = ($urandom_range(0, 39) == 0);
         step(v, 4'($urandom), c, cl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
